// File: rtl/rotator_ctrl.sv
// rotator_ctrl: sequencer for one SDF stage's interleaved re/im twiddle rotator
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   data word at rotator din this cycle; words alternate re, im
//   in_sof     with in_valid on a re word: first pair of the frame (index 0)
//   sw         rotator select, high on the accepted im-word cycle
//   twiddle    registered {cos,sin}, signed Q1.7 each
//   out_valid  rotator dout valid this cycle
//   out_im     with out_valid: 0 = real result, 1 = imaginary result
//   out_last   with out_valid & out_im: imaginary result of pair N-1
//   err        one-cycle pulse per aborted pair
package fft_pkg;
    typedef struct packed {
        logic signed [7:0] cos_q;
        logic signed [7:0] sin_q;
    } twiddle_t;
endpackage

module rotator_ctrl #(
    parameter int N_LOG2 = 6,
    parameter int STAGE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             sw,
    output fft_pkg::twiddle_t twiddle,
    output logic             out_valid,
    output logic             out_im,
    output logic             out_last,
    output logic             err
);
    localparam int N = 1 << N_LOG2;
    localparam int L = N >> STAGE;
    localparam logic [N_LOG2-1:0] LMASK = N_LOG2'(L - 1);
    localparam logic [N_LOG2-1:0] HALF  = N_LOG2'(L / 2);
    localparam fft_pkg::twiddle_t UNITY = 16'h7F00;

    // Rounded, saturated W_N^m; evaluated only at elaboration
    function automatic fft_pkg::twiddle_t calc(input int m);
        real a, c, s;
        int ci, si;
        a = 2.0 * 3.141592653589793 * m / N;
        c = 127.0 * $cos(a);
        s = -127.0 * $sin(a);
        ci = c >= 0.0 ? $rtoi(c + 0.5) : -$rtoi(0.5 - c);
        si = s >= 0.0 ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
        ci = ci > 127 ? 127 : (ci < -127 ? -127 : ci);
        si = si > 127 ? 127 : (si < -127 ? -127 : si);
        return {8'(ci), 8'(si)};
    endfunction

    fft_pkg::twiddle_t tab [N/2];
    for (genvar g = 0; g < N/2; g++) begin : g_tab
        localparam fft_pkg::twiddle_t TW = calc(g);
        assign tab[g] = TW;
    end

    typedef enum logic {RE, IM} phase_t;
    phase_t phase, phase_n;
    logic [N_LOG2-1:0] k, k_n, idx, idx_n, j;
    logic [N_LOG2-2:0] m;
    logic load, sw_d, last_d;
    fft_pkg::twiddle_t tw_n;

    always_comb begin
        phase_n = phase;
        k_n     = k;
        idx_n   = idx;
        load    = 1'b0;
        sw      = 1'b0;
        if (phase == RE) begin
            if (in_valid) begin
                phase_n = IM;
                idx_n   = in_sof ? '0 : k;
                load    = 1'b1;
            end
        end else if (in_valid && in_sof) begin
            // im slot carries a new frame's re word: restart the pair at index 0
            idx_n = '0;
            load  = 1'b1;
        end else if (in_valid) begin
            sw      = 1'b1;
            k_n     = idx + 1'b1;
            phase_n = RE;
        end else begin
            phase_n = RE;
        end
    end

    // Lower half of each block is unity; upper half steps through the table
    assign j    = idx_n & LMASK;
    assign m    = (N_LOG2-1)'((j - HALF) << STAGE);
    assign tw_n = (j < HALF) ? UNITY : tab[m];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= RE;
            k       <= '0;
            idx     <= '0;
            twiddle <= UNITY;
            sw_d    <= 1'b0;
            last_d  <= 1'b0;
            err     <= 1'b0;
        end else begin
            phase  <= phase_n;
            k      <= k_n;
            idx    <= idx_n;
            if (load) twiddle <= tw_n;
            sw_d   <= sw;
            last_d <= sw && (idx == '1);
            err    <= (phase == IM) && (!in_valid || in_sof);
        end
    end

    assign out_valid = sw | sw_d;
    assign out_im    = sw_d;
    assign out_last  = sw_d & last_d;
endmodule

// File: tb/tb_rotator_ctrl.sv
// tb_rotator_ctrl: directed vector bench for rotator_ctrl at N=8, stages 0 and 1
module tb_rotator_ctrl;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0;
    logic sw0, ov0, oim0, last0, err0, sw1, ov1, oim1, last1, err1;
    logic [15:0] tw0, tw1;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic v, sof, dc, sw, ov, oim, last, err;
        logic [15:0] t0, t1;
    } vec_t;
    vec_t vq[$];

    logic [15:0] e0 [8] = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h5AA6, 16'h0081, 16'hA6A6};
    logic [15:0] e1 [8] = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h0081, 16'h7F00, 16'h7F00, 16'h7F00, 16'h0081};

    rotator_ctrl #(.N_LOG2(3), .STAGE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .sw(sw0), .twiddle(tw0),
        .out_valid(ov0), .out_im(oim0), .out_last(last0), .err(err0));
    rotator_ctrl #(.N_LOG2(3), .STAGE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .sw(sw1), .twiddle(tw1),
        .out_valid(ov1), .out_im(oim1), .out_last(last1), .err(err1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, sof, dc, s, ov, oim, last, err, input logic [15:0] t0, t1);
        vq.push_back('{v, sof, dc, s, ov, oim, last, err, t0, t1});
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " sw"}, {15'd0, sw0}, 16'd0);
        chk({nm, " out_valid"}, {15'd0, ov0}, 16'd0);
        chk({nm, " out_valid1"}, {15'd0, ov1}, 16'd0);
        chk({nm, " err"}, {15'd0, err0}, 16'd0);
        chk({nm, " tw0"}, tw0, 16'h7F00);
        chk({nm, " tw1"}, tw1, 16'h7F00);
    endtask

    task automatic run_pair(input logic sof, input int p);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        @(negedge clk);
        in_sof = 1'b0;
        #2;
        chk($sformatf("pair%0d sw", p), {15'd0, sw0}, 16'd1);
        chk($sformatf("pair%0d tw0", p), tw0, e0[p]);
        chk($sformatf("pair%0d tw1", p), tw1, e1[p]);
    endtask

    initial begin
        // back-to-back frame with sof on the first pair
        for (int p = 0; p < 8; p++) begin
            add(1, p == 0, 0, 0, p != 0, p != 0, 0, 0,
                p == 0 ? 16'h7F00 : e0[p-1], p == 0 ? 16'h7F00 : e1[p-1]);
            add(1, 0, 0, 1, 1, 0, 0, 0, e0[p], e1[p]);
        end
        add(0, 0, 0, 0, 1, 1, 1, 0, e0[7], e1[7]);
        add(0, 0, 0, 0, 0, 0, 0, 0, e0[7], e1[7]);
        // pairs with three idle cycles between, index wraps from 7 to 0 without sof
        for (int p = 0; p < 6; p++) begin
            add(1, 0, 0, 0, 0, 0, 0, 0, p == 0 ? e0[7] : e0[p-1], p == 0 ? e1[7] : e1[p-1]);
            add(1, 0, 0, 1, 1, 0, 0, 0, e0[p], e1[p]);
            add(0, 0, 0, 0, 1, 1, 0, 0, e0[p], e1[p]);
            add(0, 0, 0, 0, 0, 0, 0, 0, e0[p], e1[p]);
            add(0, 0, 0, 0, 0, 0, 0, 0, e0[p], e1[p]);
        end
        // aborted pair at index 6, retried with the same index
        add(1, 0, 0, 0, 0, 0, 0, 0, e0[5], e1[5]);
        add(0, 0, 0, 0, 0, 0, 0, 0, e0[6], e1[6]);
        add(0, 0, 0, 0, 0, 0, 0, 1, e0[6], e1[6]);
        add(1, 0, 0, 0, 0, 0, 0, 0, e0[6], e1[6]);
        add(1, 0, 0, 1, 1, 0, 0, 0, e0[6], e1[6]);
        add(0, 0, 0, 0, 1, 1, 0, 0, e0[6], e1[6]);
        // sof arriving in the im slot restarts at index 0
        add(1, 0, 0, 0, 0, 0, 0, 0, e0[6], e1[6]);
        add(1, 1, 1, 0, 0, 0, 0, 0, e0[7], e1[7]);
        add(1, 0, 1, 0, 0, 0, 0, 1, e0[0], e1[0]);
        add(0, 0, 0, 0, 1, 1, 0, 0, e0[0], e1[0]);
        add(0, 0, 0, 0, 0, 0, 0, 0, e0[0], e1[0]);

        repeat (2) @(negedge clk);
        #2;
        chk_idle("in_reset");
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk_idle("after_reset");

        foreach (vq[i]) begin
            @(negedge clk);
            in_valid = vq[i].v;
            in_sof   = vq[i].sof;
            #2;
            chk($sformatf("row%0d err", i), {15'd0, err0}, {15'd0, vq[i].err});
            chk($sformatf("row%0d tw0", i), tw0, vq[i].t0);
            chk($sformatf("row%0d tw1", i), tw1, vq[i].t1);
            if (!vq[i].dc) begin
                chk($sformatf("row%0d sw", i), {15'd0, sw0}, {15'd0, vq[i].sw});
                chk($sformatf("row%0d out_valid", i), {15'd0, ov0}, {15'd0, vq[i].ov});
                chk($sformatf("row%0d out_im", i), {15'd0, oim0}, {15'd0, vq[i].oim});
                chk($sformatf("row%0d out_last", i), {15'd0, last0}, {15'd0, vq[i].last});
            end
        end

        // reset asserted during the im cycle of pair 5
        for (int p = 0; p < 5; p++) run_pair(p == 0, p);
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk_idle("mid_reset");
        chk("mid_reset out_im", {15'd0, oim0}, 16'd0);
        chk("mid_reset out_last", {15'd0, last0}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #2;
        chk_idle("post_reset");
        for (int p = 0; p < 6; p++) run_pair(p == 0, p);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("final out_im", {15'd0, oim0}, 16'd1);
        chk("final out_last", {15'd0, last0}, 16'd0);
        chk("final err", {15'd0, err0}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
